pattern_window_detector: RTL
============================

Name: pattern_window_detector

Overview:
Parametrised serial-bitstream pattern detector. It keeps a shared W-bit sliding window of the incoming bit and runs NCH independent detection channels on it. Each channel has a runtime-programmable pattern, a don't-care mask and an overlap/non-overlap mode, plus a saturating hit counter. A global run-of-ones lockout can freeze selected channels until they are explicitly cleared. It sits beside the existing single-purpose detectors in the lab datapath and replaces hand-coded per-sequence FSMs.

Parameters:
W, 4, window length in bits (2..16)
NCH, 2, number of detection channels (1..8)
CNT_W, 8, per-channel hit counter width
LOCK_RUN, 4, consecutive 1s that trigger lockout; 0 disables lockout
SEL_W, 1, channel-select width; must be at least $clog2(NCH), and at least 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in  in  1  serial data bit
in_valid  in  1  in is sampled only when this is 1
cfg_we  in  1  write config for channel cfg_sel
cfg_sel  in  SEL_W  channel index for config write
cfg_pattern  in  W  pattern; bit 0 = newest bit, bit W-1 = oldest
cfg_mask  in  W  1 = compare this bit, 0 = don't care
cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
cfg_lock_en  in  1  channel obeys lockout
lock_clr  in  1  clear lockout and run counter
dec  out  NCH  per-channel one-cycle match pulse
locked  out  1  lockout active
cnt_sel  in  SEL_W  channel whose counter drives cnt_out
cnt_out  out  CNT_W  hit count of channel cnt_sel (combinational mux)

Behaviour:
- Async reset (rst_n=0): window=0; all fill counters=0; run=0; locked=0; dec=0; all hit counters=0; every channel config = pattern 0, mask 0, overlap 1, lock_en 1.
- Window: on a valid cycle, next window = {window[W-2:0], in}. On an invalid cycle the window, run counter and fill counters hold, and dec=0 next cycle.
- Fill: each channel has fill[i], saturating at W. It increments on each valid cycle. A channel cannot match until W bits have entered since its last restart.
- Match for channel i on a valid cycle requires all of:
  - fill[i] >= W-1;
  - ((next window XOR pattern) AND mask) == 0;
  - not (locked_next AND lock_en[i]).
- dec[i] is registered: it pulses high for exactly 1 cycle, the cycle after the bit that completes the match. Latency is 1 clock.
- Non-overlap (overlap=0): a match sets fill[i]=0, so the next match needs W fresh bits. Overlap=1 leaves fill saturated.
- Hit counter: increments on each match and saturates at 2^CNT_W-1, never wrapping.
- Lockout:
  - run counts consecutive valid 1s, saturating at LOCK_RUN; a valid 0 resets run to 0.
  - locked_next = locked OR (run reaches LOCK_RUN this cycle).
  - Lockout takes effect in the same cycle as the completing 1.
  - While locked, lock_en channels emit no dec and do not count; other channels continue normally. The window keeps shifting.
  - lock_clr clears locked and run. lock_clr wins over a simultaneous run completion, and the current bit is not counted into run.
- Config write (cfg_we) on channel cfg_sel:
  - loads pattern, mask, overlap and lock_en;
  - clears that channel's fill and hit counter;
  - suppresses that channel's match for that cycle; the bit is still shifted into the window but does not count toward that channel's fill.
  - Other channels are unaffected.
  - If cfg_sel >= NCH, the write is ignored.
- A mask of all zeros matches every valid cycle once fill is satisfied.
- cnt_sel >= NCH gives cnt_out=0.
- Reset asserted mid-stream returns all state to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package pwd_pkg holds the channel-config record (pattern, mask, overlap, lock_en) and the reset-default constants.
- One sub-module, pwd_channel, per channel: config registers, fill counter, match compare, dec flop and hit counter.
- The top level holds the window, run/lockout logic, channel generate loop and cnt_out mux.

Test Plan:
- Ch0 configured with W=3, pattern 101, mask 111, overlap 1, lock_en 1, LOCK_RUN 4. Stream 1,0,1,0,1 -> dec[0] pulses the cycle after bits 3 and 5; cnt_out(0)=2.
- Same ch0, stream 1,1,1,1 -> locked=1 after the 4th bit. Then stream 0,1,0,1 -> no dec[0]. Then lock_clr, then 1,0,1 -> dec[0] after the 3rd bit.
- W=4, ch1 pattern 1101, mask 1111, lock_en 0. Stream 1,1,1,0,1 -> dec[1] after the 5th bit; no dec earlier.
- W=2, pattern 11, stream 1,1,1,1 -> overlap=1 gives pulses after bits 2,3,4; overlap=0 gives pulses after bits 2,4.
- CNT_W=2, mask 00 -> after 5 valid bits (W=2), cnt_out saturates at 3. A cfg_we to that channel resets cnt_out to 0 and suppresses dec that cycle.
- Drop rst_n mid-stream between clock edges -> dec, locked and cnt_out go to 0 immediately. After release, no match until W valid bits have been received.

Source files
------------

// File: rtl/pwd_pkg.sv
// Shared types for the pattern window detector: per-channel config record,
// its reset default and a width helper.
package pwd_pkg;

   localparam int W_MAX = 16;

   typedef struct packed {
      logic [W_MAX-1:0] pattern;
      logic [W_MAX-1:0] mask;
      logic             overlap;
      logic             lock_en;
   } ch_cfg_t;

   // Reset default: mask of zero means every channel matches anything once filled.
   localparam ch_cfg_t CFG_RST = '{pattern: '0, mask: '0, overlap: 1'b1, lock_en: 1'b1};

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/pwd_channel.sv
// One detection channel: config registers, fill counter, masked compare
// against the shared window, registered match pulse and saturating hit counter.
module pwd_channel
   import pwd_pkg::*;
#(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic [W-1:0]     win_i,
   input  logic             lock_i,
   input  logic             cfg_we_i,
   input  ch_cfg_t          cfg_i,
   output logic             dec_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam int                FILL_W   = clog2_min1(W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W);
   localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   ch_cfg_t           cfg_q, cfg_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dec_q, hit;
   logic [W_MAX-1:0]  diff;

   // Pattern and mask are zero above W, so the upper compare bits never fire.
   assign diff = (W_MAX'(win_i) ^ cfg_q.pattern) & cfg_q.mask;

   always_comb begin
      cfg_d  = cfg_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      hit    = 1'b0;
      if (cfg_we_i) begin
         cfg_d  = cfg_i;
         fill_d = '0;
         cnt_d  = '0;
      end else if (valid_i) begin
         hit = (fill_q >= FILL_ARM) && (diff == '0) && !(lock_i && cfg_q.lock_en);
         if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
         if (hit) begin
            if (!cfg_q.overlap) fill_d = '0;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q  <= CFG_RST;
         fill_q <= '0;
         cnt_q  <= '0;
         dec_q  <= 1'b0;
      end else begin
         cfg_q  <= cfg_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         dec_q  <= hit;
      end
   end

   assign dec_o = dec_q;
   assign cnt_o = cnt_q;

endmodule

// File: rtl/pattern_window_detector.sv
// Serial-bitstream pattern detector: shared sliding window, run-of-ones
// lockout and NCH independently programmable detection channels.
module pattern_window_detector
   import pwd_pkg::*;
#(
   parameter int W        = 4,
   parameter int NCH      = 2,
   parameter int CNT_W    = 8,
   parameter int LOCK_RUN = 4,
   parameter int SEL_W    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             in_valid,
   input  logic             cfg_we,
   input  logic [SEL_W-1:0] cfg_sel,
   input  logic [W-1:0]     cfg_pattern,
   input  logic [W-1:0]     cfg_mask,
   input  logic             cfg_overlap,
   input  logic             cfg_lock_en,
   input  logic             lock_clr,
   output logic [NCH-1:0]   dec,
   output logic             locked,
   input  logic [SEL_W-1:0] cnt_sel,
   output logic [CNT_W-1:0] cnt_out
);

   localparam int               RUN_W   = clog2_min1(LOCK_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_RUN);

   logic [W-1:0]              window_q, window_d;
   logic [RUN_W-1:0]          run_q, run_d;
   logic                      locked_q, locked_d;
   ch_cfg_t                   cfg_w;
   logic [NCH-1:0][CNT_W-1:0] cnt;

   assign window_d = in_valid ? {window_q[W-2:0], in} : window_q;

   // With LOCK_RUN=0 the run never leaves zero, so lockout can never assert.
   always_comb begin
      run_d    = run_q;
      locked_d = locked_q;
      if (lock_clr) begin
         run_d    = '0;
         locked_d = 1'b0;
      end else if (in_valid) begin
         if (!in) begin
            run_d = '0;
         end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
            if (run_d == RUN_MAX) locked_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window_q <= '0;
         run_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         window_q <= window_d;
         run_q    <= run_d;
         locked_q <= locked_d;
      end
   end

   always_comb begin
      cfg_w         = CFG_RST;
      cfg_w.pattern = W_MAX'(cfg_pattern);
      cfg_w.mask    = W_MAX'(cfg_mask);
      cfg_w.overlap = cfg_overlap;
      cfg_w.lock_en = cfg_lock_en;
   end

   // Channels see the post-shift window and post-update lock, so a match
   // and a lockout triggered by the same bit resolve in that same cycle.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      pwd_channel #(.W(W), .CNT_W(CNT_W)) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .valid_i  (in_valid),
         .win_i    (window_d),
         .lock_i   (locked_d),
         .cfg_we_i (cfg_we && (cfg_sel == SEL_W'(i))),
         .cfg_i    (cfg_w),
         .dec_o    (dec[i]),
         .cnt_o    (cnt[i])
      );
   end

   always_comb begin
      cnt_out = '0;
      for (int i = 0; i < NCH; i++) begin
         if (cnt_sel == SEL_W'(i)) cnt_out = cnt[i];
      end
   end

   assign locked = locked_q;

endmodule
